// File: rtl/ioctl_sdram_writer.sv
// Packs the data_io byte download stream into 16-bit SDRAM word writes with byte enables,
// buffers them in a small FIFO and paces data_io through clkref_n.
module ioctl_sdram_writer #(
   parameter int unsigned FIFO_AW    = 3,
   parameter logic [24:0] BASE_ADDR  = 25'd0,
   parameter int unsigned CLKREF_DIV = 4,
   parameter logic [7:0]  INDEX_SEL  = 8'hFF
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        clkref_n,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_be,
   output logic        busy,
   output logic        done,
   output logic        overflow
);

   localparam int unsigned DEPTH = 2**FIFO_AW;
   localparam int unsigned DW = (CLKREF_DIV > 2) ? $clog2(CLKREF_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKREF_DIV - 1);
   localparam logic [FIFO_AW:0] THROTTLE_CNT = (FIFO_AW+1)'(DEPTH - 2);

   typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } entry_t;

   state_t             state;
   entry_t             fifo_mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               pend_valid;
   entry_t             pend;
   logic               dl_q, start_pend;
   logic [DW-1:0]      div_cnt;

   logic [24:0] byte_addr;
   logic [23:0] byte_word;
   logic        byte_lane;
   logic [15:0] byte_data;
   logic [1:0]  byte_be;
   logic        index_ok, dl_rise, fifo_full, merge_hit;
   logic        push_en, do_push, do_pop;
   entry_t      push_entry;

   always_comb begin
      byte_addr  = BASE_ADDR + ioctl_addr;
      byte_word  = byte_addr[24:1];
      byte_lane  = byte_addr[0];
      byte_data  = byte_lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
      byte_be    = byte_lane ? 2'b10 : 2'b01;
      index_ok   = (INDEX_SEL == 8'hFF) || (ioctl_index == INDEX_SEL);
      dl_rise    = ioctl_download & ~dl_q;
      fifo_full  = count[FIFO_AW];
      merge_hit  = pend_valid && (pend.addr == byte_word) && ((pend.be & byte_be) == 2'b00);
      push_en    = 1'b0;
      push_entry = pend;
      // Any byte arriving while a word is pending closes that word: either by completing it
      // (merge) or by displacing it, so both cases push exactly one entry.
      if (state == S_ACTIVE && ioctl_wr && pend_valid) begin
         push_en = 1'b1;
         if (merge_hit)
            push_entry = {pend.addr, pend.data | byte_data, 2'b11};
      end else if (state == S_FLUSH && pend_valid) begin
         push_en = 1'b1;
      end
      do_push = push_en & ~fifo_full;
      do_pop  = mem_req & mem_ack;
   end

   always_ff @(posedge clk_sys) begin
      if (do_push)
         fifo_mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pend_valid <= 1'b0;
         pend       <= '0;
         dl_q       <= 1'b0;
         start_pend <= 1'b0;
         div_cnt    <= '0;
         clkref_n   <= 1'b1;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_be     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dl_q <= ioctl_download;

         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         if (mem_req) begin
            if (mem_ack)
               mem_req <= 1'b0;
         end else if (count != '0) begin
            mem_req <= 1'b1;
            {mem_addr, mem_din, mem_be} <= fifo_mem[rd_ptr];
         end

         clkref_n <= 1'b1;
         div_cnt  <= '0;
         if (dl_rise && index_ok && state != S_IDLE && state != S_ACTIVE)
            start_pend <= 1'b1;

         case (state)
            S_IDLE: begin
               if ((dl_rise && index_ok) || start_pend) begin
                  state      <= S_ACTIVE;
                  busy       <= 1'b1;
                  overflow   <= 1'b0;
                  start_pend <= 1'b0;
               end
            end
            S_ACTIVE: begin
               div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
               clkref_n <= ~(ioctl_download && div_cnt == DIV_LAST && count <= THROTTLE_CNT);
               if (ioctl_wr) begin
                  if (!pend_valid) begin
                     pend       <= {byte_word, byte_data, byte_be};
                     pend_valid <= 1'b1;
                  end else if (fifo_full) begin
                     overflow <= 1'b1;
                  end else if (merge_hit) begin
                     pend_valid <= 1'b0;
                  end else begin
                     pend <= {byte_word, byte_data, byte_be};
                  end
               end
               if (!ioctl_download)
                  state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (!pend_valid || !fifo_full) begin
                  pend_valid <= 1'b0;
                  state      <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (count == '0 && !mem_req) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// Scoreboard bench for ioctl_sdram_writer: a byte-to-word reference model queues expected
// SDRAM writes, and a monitor checks every req/ack handshake against that queue.
module tb_ioctl_sdram_writer;

   localparam int          DEPTH = 8;
   localparam logic [24:0] BASE  = 25'd0;
   localparam logic [7:0]  IDX   = 8'h02;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        clkref_n;
   logic        mem_req;
   logic        mem_ack;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;
   logic        busy;
   logic        done;
   logic        overflow;

   ioctl_sdram_writer #(
      .FIFO_AW    (3),
      .BASE_ADDR  (BASE),
      .CLKREF_DIV (4),
      .INDEX_SEL  (IDX)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .clkref_n       (clkref_n),
      .mem_req        (mem_req),
      .mem_ack        (mem_ack),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_be         (mem_be),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  be;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          model_occ = 0;
   bit          ack_en = 1'b1;
   int          ack_delay = 2;
   bit          exp_ovf = 1'b0;
   bit          open_v = 1'b0;
   logic [23:0] open_w;
   logic [15:0] open_d;
   logic [1:0]  open_be;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic void model_push(input logic [23:0] w, input logic [15:0] d, input logic [1:0] be);
      wr_t e;
      e.addr = w;
      e.din  = d;
      e.be   = be;
      exp_q.push_back(e);
      model_occ++;
   endfunction

   function automatic void model_open(input logic [23:0] w, input int l, input logic [7:0] d);
      open_v  = 1'b1;
      open_w  = w;
      open_d  = '0;
      open_be = '0;
      open_d[l*8 +: 8] = d;
      open_be[l] = 1'b1;
   endfunction

   // A word stays open until a byte completes it or a byte for another word/taken lane displaces it;
   // a closing byte that finds the buffer full is lost and the open word is kept.
   function automatic void model_byte(input logic [24:0] a, input logic [7:0] d);
      logic [24:0] ba;
      logic [23:0] w;
      int          l;
      ba = BASE + a;
      w  = ba[24:1];
      l  = int'(ba[0]);
      if (!open_v) begin
         model_open(w, l, d);
         return;
      end
      if (!ack_en && model_occ >= DEPTH) begin
         exp_ovf = 1'b1;
         return;
      end
      if (open_w == w && !open_be[l]) begin
         open_d[l*8 +: 8] = d;
         model_push(open_w, open_d, 2'b11);
         open_v = 1'b0;
      end else begin
         model_push(open_w, open_d, open_be);
         model_open(w, l, d);
      end
   endfunction

   function automatic void model_flush();
      if (open_v)
         model_push(open_w, open_d, open_be);
      open_v = 1'b0;
   endfunction

   // SDRAM controller stand-in: acknowledges each request after ack_delay cycles
   initial begin
      int age;
      age = 0;
      mem_ack = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         mem_ack = 1'b0;
         if (!reset && ack_en && mem_req) begin
            age++;
            if (age >= ack_delay) begin
               mem_ack = 1'b1;
               age = 0;
            end
         end else begin
            age = 0;
         end
      end
   end

   always @(negedge clk_sys) begin : monitor
      wr_t         e;
      logic [15:0] m;
      if (!reset && mem_req === 1'b1 && mem_ack === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_write unexpected act addr=%h din=%h be=%b exp none", mem_addr, mem_din, mem_be);
         end else begin
            e = exp_q.pop_front();
            model_occ--;
            m = {{8{e.be[1]}}, {8{e.be[0]}}};
            if (mem_addr !== e.addr || mem_be !== e.be || ((mem_din ^ e.din) & m) !== 16'h0) begin
               errors++;
               $display("FAIL mem_write act addr=%h din=%h be=%b exp addr=%h din=%h be=%b",
                        mem_addr, mem_din, mem_be, e.addr, e.din, e.be);
            end
         end
      end
   end

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk_sys);
      while (clkref_n !== 1'b0 && n < 300) begin
         @(negedge clk_sys);
         n++;
      end
      checks++;
      if (clkref_n !== 1'b0) begin
         errors++;
         $display("FAIL clkref_wait act=timeout exp=strobe within 300 cycles addr=%h", a);
      end else begin
         @(posedge clk_sys);
         #1;
         ioctl_wr   = 1'b1;
         ioctl_addr = a;
         ioctl_dout = d;
         model_byte(a, d);
         @(posedge clk_sys);
         #1;
         ioctl_wr = 1'b0;
      end
   endtask

   task automatic force_bytes(input logic [24:0] a0, input int n, input bit modeled);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
         ioctl_wr   = 1'b1;
         ioctl_addr = a0 + 25'(i);
         ioctl_dout = 8'($urandom);
         if (modeled)
            model_byte(ioctl_addr, ioctl_dout);
      end
      @(posedge clk_sys);
      #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic start_session(input logic [7:0] idx, input bit expect_busy);
      ioctl_index = idx;
      @(posedge clk_sys);
      #1;
      ioctl_download = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("busy_at_start", 32'(busy), 32'(expect_busy));
      if (expect_busy) begin
         exp_ovf = 1'b0;
         chk("overflow_cleared", 32'(overflow), 32'd0);
      end
   endtask

   task automatic end_session();
      int n;
      @(posedge clk_sys);
      #1;
      ioctl_download = 1'b0;
      model_flush();
      n = 0;
      @(negedge clk_sys);
      while (done !== 1'b1 && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("writes_outstanding_at_done", 32'(exp_q.size()), 32'd0);
      chk("overflow_at_done", 32'(overflow), 32'(exp_ovf));
      @(negedge clk_sys);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      logic [24:0] a;
      int          n, r, dcount;
      reset = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index = 8'h00;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_clkref_n", 32'(clkref_n), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk_sys);
      reset = 1'b0;

      // sequential 8 bytes -> four full words
      start_session(IDX, 1'b1);
      for (int i = 0; i < 8; i++)
         send_byte(25'(i), 8'(i));
      end_session();

      // odd length: last byte flushed as a half word
      start_session(IDX, 1'b1);
      send_byte(25'd0, 8'hAA);
      send_byte(25'd1, 8'hBB);
      send_byte(25'd2, 8'hCC);
      end_session();

      // odd start address, crossing a word boundary
      start_session(IDX, 1'b1);
      send_byte(25'd5, 8'h11);
      send_byte(25'd6, 8'h22);
      end_session();

      // non-matching index: no session, strobes ignored
      start_session(8'h05, 1'b0);
      force_bytes(25'd40, 4, 1'b0);
      chk("nomatch_clkref_n", 32'(clkref_n), 32'd1);
      @(posedge clk_sys);
      #1;
      ioctl_download = 1'b0;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_sys);
         if (done === 1'b1)
            dcount++;
      end
      chk("nomatch_done_count", 32'(dcount), 32'd0);
      chk("nomatch_busy", 32'(busy), 32'd0);

      // memory stalled: pacing must stop before the FIFO overflows
      start_session(IDX, 1'b1);
      ack_en = 1'b0;
      for (int i = 0; i < 2 * (DEPTH - 1); i++)
         send_byte(25'd100 + 25'(i), 8'($urandom));
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         chk("clkref_throttled", 32'(clkref_n), 32'd1);
      end
      chk("throttle_no_overflow", 32'(overflow), 32'd0);
      ack_en = 1'b1;
      for (int i = 0; i < 6; i++)
         send_byte(25'd114 + 25'(i), 8'($urandom));
      end_session();

      // unpaced strobes into a full FIFO
      start_session(IDX, 1'b1);
      ack_en = 1'b0;
      force_bytes(25'd0, 20, 1'b1);
      chk("overflow_set", 32'(overflow), 32'd1);
      chk("overflow_model", 32'(overflow), 32'(exp_ovf));
      ack_en = 1'b1;
      for (int i = 20; i < 26; i++)
         send_byte(25'(i), 8'($urandom));
      end_session();

      start_session(IDX, 1'b1);
      send_byte(25'd300, 8'h5A);
      send_byte(25'd301, 8'hA5);
      end_session();

      // randomized sessions
      for (int s = 0; s < 5; s++) begin
         ack_delay = int'($urandom_range(1, 4));
         start_session(IDX, 1'b1);
         a = 25'($urandom_range(0, 300));
         n = int'($urandom_range(1, 16));
         for (int k = 0; k < n; k++) begin
            send_byte(a, 8'($urandom));
            r = int'($urandom_range(0, 9));
            if (r < 7)
               a = a + 25'd1;
            else if (r > 7)
               a = a + 25'($urandom_range(2, 5));
         end
         end_session();
      end
      ack_delay = 2;

      // reset with FIFO half full and a request outstanding
      start_session(IDX, 1'b1);
      ack_en = 1'b0;
      for (int i = 0; i < 8; i++)
         send_byte(25'd64 + 25'(i), 8'($urandom));
      repeat (3) @(negedge clk_sys);
      chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
      #1;
      reset = 1'b1;
      ioctl_download = 1'b0;
      #1;
      chk("midreset_mem_req", 32'(mem_req), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_clkref_n", 32'(clkref_n), 32'd1);
      exp_q.delete();
      model_occ = 0;
      open_v = 1'b0;
      exp_ovf = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      ack_en = 1'b1;

      start_session(IDX, 1'b1);
      for (int i = 0; i < 4; i++)
         send_byte(25'd10 + 25'(i), 8'($urandom));
      end_session();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
